// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and default memory geometry.
package imem_loader_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_MEM_BYTES = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: zero-fills the memory, then streams a
// big-endian byte program into it while holding the CPU in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic [ADDR_W-2:0] word_count,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 1);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-2:0] WC_ONE    = (ADDR_W-1)'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-2:0] wcnt_q, wcnt_d;
  logic              done_q, done_d;
  logic              word_end;

  assign word_end = (cnt_q[1:0] == 2'b11);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    done_d     = 1'b0;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 8'h00;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          wcnt_d  = '0;
        end
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          mem_we    = 1'b1;
          mem_wdata = byte_data;
          if (word_end) wcnt_d = wcnt_q + WC_ONE;
          if (byte_last) begin
            state_d = word_end ? ST_DONE : ST_ERROR;
            done_d  = word_end;
          end else if (cnt_q == LAST_ADDR) begin
            // Overflow: park the counter at the top address instead of wrapping.
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr   = cnt_q;
  assign word_count = wcnt_q;
  assign done       = done_q;
  assign error      = (state_q == ST_ERROR);
  assign cpu_hold   = (state_q == ST_CLEAR) || (state_q == ST_LOAD) ||
                      (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as stimulus
// is driven and compared by a write monitor as the loader produces them.
module tb_imem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_last;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic [6:0] word_count;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  tb_mem[256];
  logic [7:0]  prog[8];

  imem_loader #(.ADDR_W(8), .MEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .word_count(word_count), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {16'h0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("mem_write", {16'h0, mem_addr, mem_wdata}, {16'h0, exp_q.pop_front()});
        tb_mem[mem_addr] = mem_wdata;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_wc"}, word_count, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Queue the zero-fill, pulse start, optionally re-pulse start mid-clear.
  task automatic start_load(input int restart_at);
    int n;
    for (int a = 0; a < 256; a++) exp_q.push_back({a[7:0], 8'h00});
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_hold", cpu_hold, 1);
    check("start_err_clr", error, 0);
    check("start_wc_clr", word_count, 0);
    if (restart_at > 0) begin
      repeat (restart_at) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (!byte_ready && n < 300) begin
      tick();
      n++;
    end
    check("clear_to_load", byte_ready, 1);
    check("clear_drained", exp_q.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] addr);
    int n;
    n = 0;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait", byte_ready, 1);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    exp_q.push_back({addr, d});
    tick();
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_prog(input int gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(prog[i], (i == 7), 8'(i));
      if (gap > 0 && i != 7) tick();
    end
  endtask

  task automatic check_done_seq(input string tag);
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_wc"}, word_count, 2);
    check({tag, "_drain"}, exp_q.size(), 0);
    for (int i = 0; i < 8; i++) check({tag, "_img"}, tb_mem[i], prog[i]);
    check({tag, "_nop8"}, tb_mem[8], 0);
    check({tag, "_nop255"}, tb_mem[255], 0);
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_hold_after"}, cpu_hold, 0);
  endtask

  initial begin
    prog[0] = 8'hE0; prog[1] = 8'h81; prog[2] = 8'h00; prog[3] = 8'h02;
    prog[4] = 8'hE2; prog[5] = 8'h43; prog[6] = 8'h30; prog[7] = 8'h01;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hAA;
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    #3;
    check_reset_outputs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic load
    start_load(0);
    send_prog(0);
    check_done_seq("load");

    // Same program with idle cycles between bytes
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hAA;
    start_load(0);
    send_prog(1);
    check_done_seq("gapped");

    // Partial final instruction
    start_load(0);
    for (int i = 0; i < 6; i++) send_byte(prog[i], (i == 5), 8'(i));
    check("partial_error", error, 1);
    check("partial_done", done, 0);
    check("partial_hold", cpu_hold, 1);
    check("partial_wc", word_count, 1);
    check("partial_ready", byte_ready, 0);
    check("partial_drain", exp_q.size(), 0);
    tick();
    check("partial_sticky", error, 1);

    // Overflow: 257 bytes, no last
    start_load(0);
    for (int i = 0; i < 256; i++) send_byte(8'(i ^ 8'h5A), 1'b0, 8'(i));
    check("ovf_error", error, 1);
    check("ovf_wc", word_count, 64);
    check("ovf_ready", byte_ready, 0);
    check("ovf_addr", mem_addr, 255);
    byte_valid = 1'b1; byte_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      check("ovf_no_we", mem_we, 0);
      check("ovf_no_ready", byte_ready, 0);
      tick();
    end
    byte_valid = 1'b0;
    check("ovf_drain", exp_q.size(), 0);

    // Reset in the middle of a load at address 5
    start_load(0);
    for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b0, 8'(i));
    byte_valid = 1'b1; byte_data = prog[5];
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    byte_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hAA;
    start_load(0);
    send_prog(0);
    check_done_seq("reload");

    // start pulses during clear and load are ignored
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'hAA;
    start_load(10);
    for (int i = 0; i < 4; i++) send_byte(prog[i], 1'b0, 8'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_ignored", byte_ready, 1);
    for (int i = 4; i < 8; i++) send_byte(prog[i], (i == 7), 8'(i));
    check_done_seq("nostart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width of the instruction memory being written.
REQ-002 Parameter MEM_BYTES, default 256, instruction memory depth in bytes; SHALL equal 2**ADDR_W.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; honored only in IDLE, DONE or ERROR.
REQ-006 byte_valid  input  1  source presents byte_data/byte_last.
REQ-007 byte_data  input  8  program byte, big-endian stream order (MSB byte of each instruction first).
REQ-008 byte_last  input  1  qualifies the final byte of the program.
REQ-009 byte_ready  output  1  loader accepts the byte this cycle; transfer = byte_valid & byte_ready.
REQ-010 mem_we  output  1  byte write strobe to instruction memory.
REQ-011 mem_addr  output  ADDR_W  byte address of the write.
REQ-012 mem_wdata  output  8  byte written.
REQ-013 cpu_hold  output  1  holds PC and pipeline registers in reset while high.
REQ-014 word_count  output  ADDR_W-1  number of complete 32-bit words loaded.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 error  output  1  sticky error flag, cleared by next accepted start or by reset.

Function
REQ-017 States: IDLE, CLEAR, LOAD, DONE, ERROR; one-hot or binary encoding at implementer's choice.
REQ-018 IDLE/DONE/ERROR + start -> CLEAR; address counter <= 0, error <= 0, word_count <= 0.
REQ-019 CLEAR: mem_we=1, mem_wdata=0, mem_addr=counter, one byte per cycle; takes exactly MEM_BYTES cycles so unloaded space decodes as NOP (all-zero word).
REQ-020 CLEAR -> LOAD on the cycle after address MEM_BYTES-1 is written; counter <= 0.
REQ-021 LOAD: byte_ready=1; on transfer, mem_we=1 combinationally in the same cycle, mem_addr=counter, mem_wdata=byte_data; counter increments by 1.
REQ-022 No transfer in LOAD: mem_we=0, state and counter hold; byte_valid may deassert any cycle.
REQ-023 word_count increments on each transfer whose address[1:0]==2'b11.
REQ-024 Transfer with byte_last=1 and address[1:0]==2'b11 -> DONE; done pulses for one cycle on entry.
REQ-025 Transfer with byte_last=1 and address[1:0]!=2'b11 -> ERROR (partial instruction); the byte is still written.
REQ-026 Transfer at address MEM_BYTES-1 with byte_last=0 -> ERROR (overflow); counter SHALL NOT wrap to 0 and no further writes occur.
REQ-027 byte_ready=0 and mem_we=0 in IDLE, DONE, ERROR; mem_we=0 in LOAD except per REQ-021.
REQ-028 cpu_hold=1 in CLEAR, LOAD, ERROR; 0 in IDLE and DONE.
REQ-029 start asserted during CLEAR or LOAD is ignored.
REQ-030 error=1 while in ERROR state; done and error never both high.

Reset
REQ-031 Reset low: state=IDLE, counter=0, word_count=0, done=0, error=0, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, immediately and independent of Clk.
REQ-032 Reset mid-CLEAR or mid-LOAD abandons the load; memory contents are undefined until the next completed load.
REQ-033 Reset deassertion is synchronised by the integrating level; the block requires no extra cycles after release.

Structure
REQ-034 State encoding and MEM_BYTES/ADDR_W defaults SHALL live in the shared pipeline package.
REQ-035 Single module, no sub-modules; the byte address counter is inline.

Verification
REQ-036 Reset, start, 8 bytes E0810002 E2433001 with last on 8th -> 256 zero writes, then bytes at addr 0..7, word_count=2, done pulse, cpu_hold falls with DONE.
REQ-037 Same stream with byte_valid toggled every other cycle -> identical memory image and word_count=2; no write on idle cycles.
REQ-038 6 bytes, last on 6th -> ERROR, error=1, bytes 0..5 written, word_count=1, cpu_hold stays 1.
REQ-039 257 bytes without last -> ERROR after addr 255 write, byte 257 not accepted, mem_we never asserted at wrapped addr 0.
REQ-040 Reset asserted low mid-LOAD at addr 5 -> all outputs to REQ-031 values same cycle; new start then reloads from addr 0.
REQ-041 start pulsed during CLEAR and LOAD -> no restart; sequence completes as in REQ-036.
